// File: rtl/execute_flag_cond.sv
// Flag-dependent condition evaluator: waits until every older flag-writing
// instruction has committed, then evaluates a condition code on the flag register.
module execute_flag_cond #(
    parameter int P_CNT_W = 3
) (
    input  logic       iCLOCK,
    input  logic       inRESET,
    input  logic       iRESET_SYNC,
    input  logic [4:0] iFLAG,
    input  logic       iFLAG_WR_ISSUE,
    input  logic       iFLAG_WR_DONE,
    input  logic       iCOND_VALID,
    input  logic [3:0] iCOND_CODE,
    output logic       oCOND_BUSY,
    output logic       oRESULT_VALID,
    output logic       oRESULT,
    input  logic       iNEXT_BUSY,
    output logic       oFLAG_PENDING,
    output logic       oFLAG_FULL
);

    typedef enum logic [1:0] {
        L_IDLE,
        L_WAIT,
        L_OUT
    } stateT;

    stateT              state, stateNext;
    logic [P_CNT_W-1:0] pending, pendingNext;
    logic [P_CNT_W-1:0] waitCnt, waitNext;
    logic [3:0]         code, codeNext;
    logic               result, resultNext;
    logic               valid, validNext;

    function automatic logic evalCond(input logic [3:0] cc, input logic [4:0] fl);
        logic z, p, c, o, s;
        {s, o, c, p, z} = fl;
        case (cc)
            4'd0:    evalCond = 1'b1;
            4'd1:    evalCond = z;
            4'd2:    evalCond = !z;
            4'd3:    evalCond = c;
            4'd4:    evalCond = !c;
            4'd5:    evalCond = s;
            4'd6:    evalCond = !s;
            4'd7:    evalCond = o;
            4'd8:    evalCond = !o;
            4'd9:    evalCond = c && !z;
            4'd10:   evalCond = !c || z;
            4'd11:   evalCond = (s == o);
            4'd12:   evalCond = (s != o);
            4'd13:   evalCond = !z && (s == o);
            4'd14:   evalCond = z || (s != o);
            default: evalCond = p;
        endcase
    endfunction

    always_comb begin
        pendingNext = pending;
        if (iFLAG_WR_ISSUE && !iFLAG_WR_DONE && pending != '1)
            pendingNext = pending + P_CNT_W'(1);
        else if (iFLAG_WR_DONE && !iFLAG_WR_ISSUE && pending != '0)
            pendingNext = pending - P_CNT_W'(1);

        stateNext  = state;
        waitNext   = waitCnt;
        codeNext   = code;
        resultNext = result;
        validNext  = valid;
        case (state)
            L_IDLE: begin
                if (iCOND_VALID) begin
                    codeNext  = iCOND_CODE;
                    // a write committing in the accept cycle is already behind us
                    waitNext  = pending - P_CNT_W'(iFLAG_WR_DONE && pending != '0);
                    stateNext = L_WAIT;
                end
            end
            L_WAIT: begin
                if (waitCnt != '0) begin
                    if (iFLAG_WR_DONE)
                        waitNext = waitCnt - P_CNT_W'(1);
                end else begin
                    resultNext = evalCond(code, iFLAG);
                    validNext  = 1'b1;
                    stateNext  = L_OUT;
                end
            end
            L_OUT: begin
                if (!iNEXT_BUSY) begin
                    validNext = 1'b0;
                    stateNext = L_IDLE;
                end
            end
            default: stateNext = L_IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state   <= L_IDLE;
            pending <= '0;
            waitCnt <= '0;
            code    <= '0;
            result  <= 1'b0;
            valid   <= 1'b0;
        end else if (iRESET_SYNC) begin
            state   <= L_IDLE;
            pending <= '0;
            waitCnt <= '0;
            code    <= '0;
            result  <= 1'b0;
            valid   <= 1'b0;
        end else begin
            state   <= stateNext;
            pending <= pendingNext;
            waitCnt <= waitNext;
            code    <= codeNext;
            result  <= resultNext;
            valid   <= validNext;
        end
    end

    assign oCOND_BUSY    = (state != L_IDLE);
    assign oRESULT_VALID = valid;
    assign oRESULT       = result;
    assign oFLAG_PENDING = (pending != '0);
    assign oFLAG_FULL    = (pending == '1);

endmodule
